// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: pixel tick into the generator, sync/enable/position/strobes out.
// The generator uses the master modport; framebuffer reader and pin drivers use slave.
interface vga_timing_gen_if #(
    parameter int XW = 10,
    parameter int YW = 10
);
    logic          pix_en;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          line_start;
    logic          frame_start;

    modport master (
        input  pix_en,
        output hsync, vsync, de, x, y, line_start, frame_start
    );

    modport slave (
        output pix_en,
        input  hsync, vsync, de, x, y, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: all outputs registered, one enabled tick behind the h/v counters.
// No backpressure; pix_en only qualifies advancement, strobes are one clk wide per tick.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int XW       = 10,
    parameter int YW       = 10
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
            $error("vga_timing_gen: every timing parameter must be >= 1");
        end
        if (XW < 1 || YW < 1 || XW > 30 || YW > 30 ||
            H_TOTAL > (1 << XW) || V_TOTAL > (1 << YW)) begin : g_bad_width
            $error("vga_timing_gen: XW/YW too narrow for the raster totals");
        end
    endgenerate

    localparam logic [XW-1:0] H_LAST    = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT_END = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_BEG    = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END    = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] V_LAST    = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT_END = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_BEG    = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END    = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          HS_ON     = (HS_POL != 0);
    localparam logic          VS_ON     = (VS_POL != 0);

    logic [XW-1:0] h_q, h_d;
    logic [YW-1:0] v_q, v_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;

    always_comb begin
        h_d           = h_q;
        v_d           = v_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        x_d           = x_q;
        y_d           = y_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (rst) begin
            h_d     = '0;
            v_d     = '0;
            hsync_d = ~HS_ON;
            vsync_d = ~VS_ON;
            de_d    = 1'b0;
            x_d     = '0;
            y_d     = '0;
        end else if (bus.pix_en) begin
            // Decode the position the counters hold now; it becomes the presented pixel.
            de_d          = (h_q < H_ACT_END) && (v_q < V_ACT_END);
            hsync_d       = (h_q >= HS_BEG && h_q < HS_END) ? HS_ON : ~HS_ON;
            vsync_d       = (v_q >= VS_BEG && v_q < VS_END) ? VS_ON : ~VS_ON;
            x_d           = h_q;
            y_d           = v_q;
            line_start_d  = (h_q == '0);
            frame_start_d = (h_q == '0) && (v_q == '0);
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        h_q           <= h_d;
        v_q           <= v_d;
        hsync_q       <= hsync_d;
        vsync_q       <= vsync_d;
        de_q          <= de_d;
        x_q           <= x_d;
        y_q           <= y_d;
        line_start_q  <= line_start_d;
        frame_start_q <= frame_start_d;
    end

    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.de          = de_q;
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for line timing, 17x12 instances for frame,
// gating, mid-frame reset and sync polarity.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst;
    logic pix_en;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.XW(10), .YW(10)) bus_def ();
    vga_timing_gen_if #(.XW(5),  .YW(4))  bus_sml ();
    vga_timing_gen_if #(.XW(5),  .YW(4))  bus_pol ();

    assign bus_def.pix_en = pix_en;
    assign bus_sml.pix_en = pix_en;
    assign bus_pol.pix_en = pix_en;

    vga_timing_gen u_def (.clk(clk), .rst(rst), .bus(bus_def));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(5), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .XW(5), .YW(4)
    ) u_sml (.clk(clk), .rst(rst), .bus(bus_sml));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(5), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HS_POL(1), .VS_POL(1), .XW(5), .YW(4)
    ) u_pol (.clk(clk), .rst(rst), .bus(bus_pol));

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int de_cnt, hs_lo, ls_cnt, pos_err;
        int vs_lo, phs, pvs, fs_cnt, fs_gap, last_fs, first_vs_y, xchg, wide, early;
        logic prev_fs;
        int prev_x;

        // Reset with pix_en high
        rst = 1'b1;
        pix_en = 1'b1;
        repeat (3) tick;
        chk("rst_hsync", int'(bus_def.hsync), 1);
        chk("rst_vsync", int'(bus_def.vsync), 1);
        chk("rst_de", int'(bus_def.de), 0);
        chk("rst_x", int'(bus_def.x), 0);
        chk("rst_y", int'(bus_def.y), 0);
        chk("rst_ls", int'(bus_def.line_start), 0);
        chk("rst_fs", int'(bus_def.frame_start), 0);
        chk("pol_rst_hsync", int'(bus_pol.hsync), 0);
        chk("pol_rst_vsync", int'(bus_pol.vsync), 0);

        rst = 1'b0;
        tick;
        chk("first_x", int'(bus_def.x), 0);
        chk("first_y", int'(bus_def.y), 0);
        chk("first_de", int'(bus_def.de), 1);
        chk("first_fs", int'(bus_def.frame_start), 1);
        chk("first_ls", int'(bus_def.line_start), 1);
        chk("pol_first_hsync", int'(bus_pol.hsync), 0);

        // Two full default lines
        de_cnt = 0; hs_lo = 0; ls_cnt = 0; pos_err = 0;
        for (int i = 0; i < 1600; i++) begin
            if (int'(bus_def.x) != i % 800 || int'(bus_def.y) != i / 800) pos_err++;
            if (bus_def.de) de_cnt++;
            if (!bus_def.hsync) hs_lo++;
            if (bus_def.line_start) ls_cnt++;
            case (i)
                639: chk("de_x639", int'(bus_def.de), 1);
                640: chk("de_x640", int'(bus_def.de), 0);
                655: chk("hs_x655", int'(bus_def.hsync), 1);
                656: chk("hs_x656", int'(bus_def.hsync), 0);
                751: chk("hs_x751", int'(bus_def.hsync), 0);
                752: chk("hs_x752", int'(bus_def.hsync), 1);
                800: chk("ls_x0_line1", int'(bus_def.line_start), 1);
                default: ;
            endcase
            tick;
        end
        chk("h_pos_err", pos_err, 0);
        chk("h_de_cnt", de_cnt, 1280);
        chk("h_hs_lo_cnt", hs_lo, 192);
        chk("h_ls_cnt", ls_cnt, 2);

        // Two full small frames (17 x 12 = 204 ticks each) and the wrap
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tick;
        de_cnt = 0; hs_lo = 0; ls_cnt = 0; pos_err = 0;
        vs_lo = 0; phs = 0; pvs = 0; fs_cnt = 0; fs_gap = 0; last_fs = 0; first_vs_y = -1;
        for (int i = 0; i < 408; i++) begin
            if (int'(bus_sml.x) != i % 17 || int'(bus_sml.y) != (i / 17) % 12) pos_err++;
            if (bus_sml.de) de_cnt++;
            if (!bus_sml.hsync) hs_lo++;
            if (!bus_sml.vsync) begin
                vs_lo++;
                if (first_vs_y < 0) first_vs_y = int'(bus_sml.y);
            end
            if (bus_pol.hsync) phs++;
            if (bus_pol.vsync) pvs++;
            if (bus_sml.line_start) ls_cnt++;
            if (bus_sml.frame_start) begin
                fs_cnt++;
                fs_gap = i - last_fs;
                last_fs = i;
            end
            if (i == 407) begin
                chk("last_x", int'(bus_sml.x), 16);
                chk("last_y", int'(bus_sml.y), 11);
            end
            tick;
        end
        chk("f_pos_err", pos_err, 0);
        chk("f_de_cnt", de_cnt, 80);
        chk("f_hs_lo_cnt", hs_lo, 72);
        chk("f_vs_lo_cnt", vs_lo, 68);
        chk("f_first_vs_y", first_vs_y, 7);
        chk("pol_hs_hi_cnt", phs, 72);
        chk("pol_vs_hi_cnt", pvs, 68);
        chk("f_ls_cnt", ls_cnt, 24);
        chk("f_fs_cnt", fs_cnt, 2);
        chk("f_fs_gap", fs_gap, 204);
        chk("wrap_x", int'(bus_sml.x), 0);
        chk("wrap_y", int'(bus_sml.y), 0);
        chk("wrap_fs", int'(bus_sml.frame_start), 1);

        // Reset with pix_en low, then pix_en 1 clk in 5
        pix_en = 1'b0;
        rst = 1'b1;
        tick;
        chk("rst_lo_en_x", int'(bus_sml.x), 0);
        chk("rst_lo_en_vsync", int'(bus_sml.vsync), 1);
        chk("rst_lo_en_fs", int'(bus_sml.frame_start), 0);
        rst = 1'b0;
        prev_x = int'(bus_sml.x);
        prev_fs = 1'b0;
        xchg = 0; fs_cnt = 0; fs_gap = 0; last_fs = 0; ls_cnt = 0; wide = 0; pos_err = 0;
        for (int k = 0; k <= 1020; k++) begin
            pix_en = (k % 5 == 0);
            tick;
            if (int'(bus_sml.x) != prev_x) xchg++;
            if (int'(bus_sml.x) != (k / 5) % 17 || int'(bus_sml.y) != (k / 85) % 12) pos_err++;
            if (bus_sml.frame_start) begin
                fs_cnt++;
                fs_gap = k - last_fs;
                last_fs = k;
                if (prev_fs) wide++;
            end
            if (bus_sml.line_start) ls_cnt++;
            if (k == 3) begin
                chk("g_hold_de", int'(bus_sml.de), 1);
                chk("g_fs_one_clk", int'(bus_sml.frame_start), 0);
            end
            prev_x = int'(bus_sml.x);
            prev_fs = bus_sml.frame_start;
        end
        pix_en = 1'b1;
        chk("g_x_changes", xchg, 204);
        chk("g_pos_err", pos_err, 0);
        chk("g_fs_cnt", fs_cnt, 2);
        chk("g_fs_period", fs_gap, 1020);
        chk("g_fs_wide", wide, 0);
        chk("g_ls_cnt", ls_cnt, 13);

        // Mid-frame reset at (5,3), then no vsync before y=7
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tick;
        repeat (56) tick;
        chk("mid_pre_x", int'(bus_sml.x), 5);
        chk("mid_pre_y", int'(bus_sml.y), 3);
        rst = 1'b1;
        tick;
        chk("mid_rst_x", int'(bus_sml.x), 0);
        chk("mid_rst_y", int'(bus_sml.y), 0);
        chk("mid_rst_de", int'(bus_sml.de), 0);
        chk("mid_rst_hsync", int'(bus_sml.hsync), 1);
        chk("mid_rst_vsync", int'(bus_sml.vsync), 1);
        chk("mid_rst_ls", int'(bus_sml.line_start), 0);
        chk("mid_rst_def_de", int'(bus_def.de), 0);
        rst = 1'b0;
        tick;
        chk("mid_new_x", int'(bus_sml.x), 0);
        chk("mid_new_y", int'(bus_sml.y), 0);
        chk("mid_new_de", int'(bus_sml.de), 1);
        chk("mid_new_fs", int'(bus_sml.frame_start), 1);
        chk("mid_new_ls", int'(bus_sml.line_start), 1);
        early = 0;
        for (int i = 0; i < 119; i++) begin
            if (!bus_sml.vsync) early++;
            tick;
        end
        chk("mid_no_early_vs", early, 0);
        chk("mid_vs_y", int'(bus_sml.y), 7);
        chk("mid_vs_lvl", int'(bus_sml.vsync), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Raster timing generator for the display path. It sits directly downstream of the pixel clock divider and consumes its pixel rate as a qualifying strobe. It produces hsync/vsync, data-enable, the current pixel coordinate, and frame/line start strobes for the framebuffer reader and the VGA pins. Default timing is 640x480 @ 60 Hz (800x525 total).

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level (0 = active-low)
XW, 10, width of x; must hold H_TOTAL-1
YW, 10, width of y; must hold V_TOTAL-1

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
pix_en  in  1  pixel tick; timing advances only on clk edges with pix_en=1 (tie to 1 if clk is the pixel clock)
hsync  out  1  horizontal sync, level per HS_POL
vsync  out  1  vertical sync, level per VS_POL
de  out  1  data enable; 1 inside active area
x  out  XW  horizontal position of presented pixel, 0..H_TOTAL-1
y  out  YW  vertical position of presented line, 0..V_TOTAL-1
line_start  out  1  1-clk strobe when presented x==0
frame_start  out  1  1-clk strobe when presented (x,y)==(0,0)

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Every parameter must be >=1; elaboration fails otherwise.
- Line order: active, front porch, sync, back porch. Frame order is the same, in whole lines.
- Internal counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1).
- On a clk edge with pix_en=1:
  - Output registers load the decode of the current (h,v).
  - Then h increments.
  - At h==H_TOTAL-1, h wraps to 0 and v increments.
  - At v==V_TOTAL-1 together with the h wrap, v wraps to 0.
- Outputs are therefore registered and lag the counters by exactly one enabled tick. All outputs are mutually aligned: hsync, vsync, de and the strobes always describe the (x,y) presented in the same cycle.
- Decode for position (h,v):
  - de = (h < H_ACTIVE) and (v < V_ACTIVE).
  - hsync is at its active level iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; otherwise it is at the inactive level.
  - vsync is at its active level iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for the whole line including blanking.
  - x = h, y = v (raw, not clamped in blanking).
- On a clk edge with pix_en=0:
  - Counters and hsync/vsync/de/x/y hold.
  - line_start and frame_start clear to 0. Each strobe is high for exactly one clk cycle per presented pixel, regardless of pix_en duty.
- Reset (rst=1 on a clk edge), regardless of pix_en:
  - h=0, v=0.
  - hsync=~HS_POL, vsync=~VS_POL.
  - de=0, x=0, y=0.
  - line_start=0, frame_start=0.
- Reset mid-frame:
  - Aborts the frame immediately with no partial sync extension.
  - The first enabled tick after rst deasserts presents (0,0) with de=1, line_start=1, frame_start=1.
- Simultaneous rst and pix_en: rst wins.
- No other state exists. No combinational path from pix_en to any output.

Test Plan:
- Reset: hold rst 3 cycles, pix_en=1 -> hsync=1, vsync=1, de=0, x=0, y=0, strobes 0. On the first cycle after release, x=0, y=0, de=1, frame_start=1, line_start=1.
- Horizontal timing (defaults, pix_en=1): de=1 for x=0..639 and 0 at x=640. hsync=0 exactly for x=656..751 (96 cycles), 1 at x=752. line_start every 800 cycles.
- Vertical timing and wrap: vsync=0 for all of y=490..491 (1600 cycles). de=0 for y>=480. frame_start recurs exactly 420000 enabled ticks after the previous one. After (799,524) the next presented position is (0,0).
- pix_en gating: pix_en high 1 cycle in 5 -> x advances once per 5 clks. Outputs hold between ticks. line_start/frame_start are 1 clk wide only. Frame period = 2100000 clks.
- Mid-frame reset: at (300,200) assert rst 1 cycle -> next cycle shows reset values. The following enabled tick presents (0,0) with frame_start=1. No vsync pulse occurs before y=490 of the new frame.
- Polarity: HS_POL=1, VS_POL=1 -> reset levels are hsync=0, vsync=0. hsync=1 exactly for x=656..751, vsync=1 for y=490..491.
